// File: rtl/espic_pkg.sv
// Shared definitions for the espic interrupt controller: opcode constants,
// pulse FSM states, opcode classification and priority arbitration.
package espic_pkg;

  localparam logic [9:0]  OP_SET_PRIO = 10'h2F1;
  localparam logic [11:0] OP_RAISE    = 12'h3F1;
  localparam logic [9:0]  OP_SET_MASK = 10'h2F2;

  localparam int MAX_NODES  = 15;
  localparam int PRIO_MAX_W = 8;

  typedef enum logic {PG_IDLE, PG_ACTIVE} pg_state_e;

  typedef enum logic [1:0] {OPK_NONE, OPK_SET_PRIO, OPK_RAISE, OPK_SET_MASK} op_kind_e;

  typedef struct packed {
    logic       vld;
    logic [3:0] idx;
  } arb_t;

  // Classifies an opcode from its upper field op[15:4].
  function automatic op_kind_e op_decode(input logic [11:0] op_hi);
    op_kind_e kind;
    kind = OPK_NONE;
    if (op_hi == OP_RAISE)
      kind = OPK_RAISE;
    else if (op_hi[9:0] == OP_SET_PRIO)
      kind = OPK_SET_PRIO;
    else if (op_hi[9:0] == OP_SET_MASK)
      kind = OPK_SET_MASK;
    return kind;
  endfunction

  // Highest priority among enabled nodes; strict compare keeps the lowest index on ties.
  function automatic arb_t arb_pick(input logic [MAX_NODES*PRIO_MAX_W-1:0] prio,
                                    input logic [MAX_NODES-1:0]            en);
    arb_t                  r;
    logic [PRIO_MAX_W-1:0] best;
    r    = '0;
    best = '0;
    for (int k = 0; k < MAX_NODES; k++) begin
      if (en[k] && (!r.vld || prio[k*PRIO_MAX_W +: PRIO_MAX_W] > best)) begin
        r.vld = 1'b1;
        r.idx = 4'(k);
        best  = prio[k*PRIO_MAX_W +: PRIO_MAX_W];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/espic_pulse_gen.sv
// Fixed-length pulse generator with a single-entry pending flag; a pending
// request re-fires after exactly one low cycle.
module espic_pulse_gen
  import espic_pkg::*;
#(
  parameter int PULSE_LEN = 1001
) (
  input  logic CLK,
  input  logic RST,
  input  logic req,
  output logic out,
  output logic busy
);

  localparam int              CNT_W = $clog2(PULSE_LEN + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(PULSE_LEN);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  pg_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= PG_IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    case (state_q)
      PG_IDLE: begin
        if (req || pend_q) begin
          state_d = PG_ACTIVE;
          cnt_d   = ONE;
          pend_d  = 1'b0;
        end
      end
      PG_ACTIVE: begin
        // Only one request can wait; further ones merge into it.
        if (req) pend_d = 1'b1;
        if (cnt_q == LAST) begin
          state_d = PG_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: begin
        state_d = PG_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign out  = (state_q == PG_ACTIVE);
  assign busy = out | pend_q;

endmodule

// File: rtl/espic_multi.sv
// Multi-node interrupt controller: broadcast tick, priority-arbitrated external
// event grant and node-to-node command IRQs. Optional node masking: ESPIC_MASK_EN.
module espic_multi
  import espic_pkg::*;
#(
  parameter int N_NODES     = 2,
  parameter int OP_W        = 16,
  parameter int PRIO_W      = 4,
  parameter int TICK_PERIOD = 1000000000,
  parameter int TICK_LEN    = 100,
  parameter int PULSE_LEN   = 1001,
  parameter int PRIO_RST    = 0
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    ext_signal,
  input  logic [N_NODES*OP_W-1:0] in_op,
  output logic                    out_tick_irq,
  output logic [N_NODES-1:0]      out_mutex_irq,
  output logic [N_NODES-1:0]      out_cmd_irq,
  output logic                    out_busy
);

  localparam int CNT_MAX = (TICK_PERIOD > PULSE_LEN) ? TICK_PERIOD : PULSE_LEN;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_PERIOD - 1);
  localparam logic [CNT_W-1:0] TICK_ON   = CNT_W'(TICK_PERIOD - TICK_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [CNT_W-1:0]              tick_cnt_q, tick_cnt_d;
  logic [N_NODES-1:0][PRIO_W-1:0] prio_q, prio_d;
  logic [N_NODES-1:0]            raise_vec;
  logic [N_NODES-1:0]            en;
  logic [OP_W-1:0]               op_k;
  logic                          sync1_q, sync2_q, sync3_q;
  logic                          mutex_req, mutex_active;
  logic [MAX_NODES*PRIO_MAX_W-1:0] prio_flat;
  logic [MAX_NODES-1:0]          en_flat;
  arb_t                          arb;
  logic [N_NODES-1:0]            arb_oh;
  logic [N_NODES-1:0]            grant_q;
  logic [N_NODES-1:0]            cmd_busy_unused;

  // Tick: free-running counter, pulse occupies the last TICK_LEN counts.
  always_comb tick_cnt_d = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + CNT_ONE;

  always_ff @(posedge CLK) begin
    if (RST) tick_cnt_q <= '0;
    else     tick_cnt_q <= tick_cnt_d;
  end

  assign out_tick_irq = (tick_cnt_q >= TICK_ON);

`ifdef ESPIC_MASK_EN
  logic [N_NODES-1:0] en_q, en_d;

  always_ff @(posedge CLK) begin
    if (RST) en_q <= '1;
    else     en_q <= en_d;
  end

  assign en = en_q;
`else
  assign en = '1;
`endif

  // Opcode decode; raises are combinational so the pulse state register is their only delay.
  always_comb begin
    prio_d    = prio_q;
    raise_vec = '0;
    op_k      = '0;
`ifdef ESPIC_MASK_EN
    en_d      = en_q;
`endif
    for (int k = 0; k < N_NODES; k++) begin
      op_k = in_op[k*OP_W +: OP_W];
      case (op_decode(op_k[15:4]))
        OPK_SET_PRIO: prio_d[k] = op_k[PRIO_W-1:0];
        OPK_RAISE: begin
          for (int t = 0; t < N_NODES; t++)
            if (op_k[3:0] == 4'(t + 1)) raise_vec[t] = 1'b1;
        end
        OPK_SET_MASK: begin
`ifdef ESPIC_MASK_EN
          en_d[k] = op_k[0];
`endif
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) prio_q <= {N_NODES{PRIO_W'(PRIO_RST)}};
    else     prio_q <= prio_d;
  end

  // External event: two-flop synchroniser, third flop for rising-edge detect.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= ext_signal;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign mutex_req = sync2_q & ~sync3_q & (|en);

  always_comb begin
    prio_flat = '0;
    en_flat   = '0;
    for (int k = 0; k < N_NODES; k++) begin
      prio_flat[k*PRIO_MAX_W +: PRIO_MAX_W] = PRIO_MAX_W'(prio_q[k]);
      en_flat[k] = en[k];
    end
  end

  assign arb = arb_pick(prio_flat, en_flat);

  always_comb begin
    arb_oh = '0;
    for (int k = 0; k < N_NODES; k++)
      arb_oh[k] = arb.vld && (arb.idx == 4'(k));
  end

  espic_pulse_gen #(.PULSE_LEN(PULSE_LEN)) u_mutex_pg (
    .CLK  (CLK),
    .RST  (RST),
    .req  (mutex_req),
    .out  (mutex_active),
    .busy (out_busy)
  );

  // Grant tracks arbitration while idle and freezes on the edge the pulse starts,
  // so a pending re-entry is re-arbitrated in its low gap cycle.
  always_ff @(posedge CLK) begin
    if (RST)               grant_q <= '0;
    else if (!mutex_active) grant_q <= arb_oh;
  end

  assign out_mutex_irq = grant_q & {N_NODES{mutex_active}};

  for (genvar g = 0; g < N_NODES; g++) begin : g_cmd
    espic_pulse_gen #(.PULSE_LEN(PULSE_LEN)) u_cmd_pg (
      .CLK  (CLK),
      .RST  (RST),
      .req  (raise_vec[g] & en[g]),
      .out  (out_cmd_irq[g]),
      .busy (cmd_busy_unused[g])
    );
  end

endmodule

// File: tb/tb_espic_multi.sv
// Directed bench for espic_multi with N_NODES=3, TICK_PERIOD=50, TICK_LEN=5, PULSE_LEN=8.
module tb_espic_multi;

  localparam int N  = 3;
  localparam int TP = 50;
  localparam int TL = 5;
  localparam int PL = 8;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          ext_signal = 1'b0;
  logic [N*16-1:0] in_op = '0;
  logic          out_tick_irq;
  logic [N-1:0]  out_mutex_irq;
  logic [N-1:0]  out_cmd_irq;
  logic          out_busy;

  int errs   = 0;
  int checks = 0;

  espic_multi #(
    .N_NODES(N), .OP_W(16), .PRIO_W(4), .TICK_PERIOD(TP),
    .TICK_LEN(TL), .PULSE_LEN(PL), .PRIO_RST(0)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .ext_signal    (ext_signal),
    .in_op         (in_op),
    .out_tick_irq  (out_tick_irq),
    .out_mutex_irq (out_mutex_irq),
    .out_cmd_irq   (out_cmd_irq),
    .out_busy      (out_busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_op(input int node, input logic [15:0] v);
    in_op[node*16 +: 16] = v;
  endtask

  task automatic op_pulse(input int node, input logic [15:0] v);
    set_op(node, v);
    @(negedge CLK);
    set_op(node, 16'h0);
  endtask

  // ext rises at N0; grant visible N3..N10. Optional late opcode lands on the arbitration edge.
  task automatic mutex_burst(input string tag, input logic [2:0] exp,
                             input int late_node = -1, input logic [15:0] late_op = 16'h0);
    ext_signal = 1'b1;
    @(negedge CLK);
    chk({tag, "_pre"}, 32'(out_mutex_irq), 32'(0));
    @(negedge CLK);
    ext_signal = 1'b0;
    if (late_node >= 0) set_op(late_node, late_op);
    for (int i = 0; i < PL; i++) begin
      @(negedge CLK);
      if (i == 0 && late_node >= 0) set_op(late_node, 16'h0);
      chk(tag, 32'(out_mutex_irq), 32'(exp));
      if (i == 0) chk({tag, "_busy"}, 32'(out_busy), 32'(1));
    end
    @(negedge CLK);
    chk({tag, "_end"}, 32'(out_mutex_irq), 32'(0));
    chk({tag, "_idle"}, 32'(out_busy), 32'(0));
    repeat (3) @(negedge CLK);
  endtask

  // Node 0 drives op for one cycle; expected cmd vector for 8 cycles then low.
  task automatic cmd_burst(input string tag, input logic [15:0] op, input logic [2:0] exp);
    set_op(0, op);
    for (int i = 0; i < PL; i++) begin
      @(negedge CLK);
      if (i == 0) set_op(0, 16'h0);
      chk(tag, 32'(out_cmd_irq), 32'(exp));
    end
    @(negedge CLK);
    chk({tag, "_end"}, 32'(out_cmd_irq), 32'(0));
    repeat (2) @(negedge CLK);
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    chk("rst_tick",  32'(out_tick_irq),  32'(0));
    chk("rst_mutex", 32'(out_mutex_irq), 32'(0));
    chk("rst_cmd",   32'(out_cmd_irq),   32'(0));
    chk("rst_busy",  32'(out_busy),      32'(0));

    // Cycle 0 is the cycle in which RST is first low.
    RST = 1'b0;
    for (int c = 0; c <= 100; c++) begin
      if (c > 0) @(negedge CLK);
      chk("tick", 32'(out_tick_irq), 32'((c % TP) >= (TP - TL)));
    end

    set_op(1, 16'h2F13);
    set_op(2, 16'h2F17);
    @(negedge CLK);
    set_op(1, 16'h0);
    set_op(2, 16'h0);
    mutex_burst("prio_n2", 3'b100);
    op_pulse(2, 16'h2F10);
    mutex_burst("prio_n1", 3'b010);
    op_pulse(1, 16'h2F10);
    mutex_burst("tie0", 3'b001);
    mutex_burst("late_prio", 3'b001, 2, 16'h2F19);
    mutex_burst("late_seen", 3'b100);
    op_pulse(2, 16'h2F10);

    cmd_burst("raise2", 16'h3F13, 3'b100);
    cmd_burst("raise0", 16'h3F11, 3'b001);
    cmd_burst("raise_t0", 16'h3F10, 3'b000);
    cmd_burst("raise_t4", 16'h3F14, 3'b000);

    // Pending: edges at N0, N4, N6; two grants with one low cycle between.
    ext_signal = 1'b1;
    for (int n = 1; n <= 31; n++) begin
      @(negedge CLK);
      ext_signal = (n == 4 || n == 6);
      chk("pend_mutex", 32'(out_mutex_irq),
          32'(((n >= 3 && n <= 10) || (n >= 12 && n <= 19)) ? 3'b001 : 3'b000));
      chk("pend_busy", 32'(out_busy), 32'(n >= 3 && n <= 19));
    end
    repeat (3) @(negedge CLK);

    // Reset mid-pulse with a pending grant and an active cmd pulse.
    op_pulse(2, 16'h2F15);
    ext_signal = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      @(negedge CLK);
      ext_signal = (n == 2);
      if (n == 3) set_op(0, 16'h3F12);
      if (n == 4) set_op(0, 16'h0);
    end
    chk("rstm_pre_mutex", 32'(out_mutex_irq), 32'(3'b100));
    chk("rstm_pre_cmd",   32'(out_cmd_irq),   32'(3'b010));
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("rstm_tick",  32'(out_tick_irq),  32'(0));
    chk("rstm_mutex", 32'(out_mutex_irq), 32'(0));
    chk("rstm_cmd",   32'(out_cmd_irq),   32'(0));
    chk("rstm_busy",  32'(out_busy),      32'(0));
    for (int n = 0; n < 12; n++) begin
      @(negedge CLK);
      chk("rstm_nopend", 32'({out_busy, out_mutex_irq}), 32'(0));
    end
    mutex_burst("rstm_prio0", 3'b001);

    set_op(1, 16'h2F13);
    set_op(2, 16'h2F17);
    @(negedge CLK);
    set_op(1, 16'h0);
    set_op(2, 16'h0);
    op_pulse(2, 16'h2F20);
`ifdef ESPIC_MASK_EN
    mutex_burst("mask_n2", 3'b010);
    cmd_burst("mask_raise", 16'h3F13, 3'b000);
    op_pulse(2, 16'h2F21);
    mutex_burst("unmask_n2", 3'b100);
`else
    mutex_burst("nomask_n2", 3'b100);
    cmd_burst("nomask_raise", 16'h3F13, 3'b100);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
